// File: rtl/patch_embed_reader.sv
// patch_embed_reader
//   Streams NUM_WORDS words out of an embedded RAM (2-cycle read latency)
//   into a first-word-fall-through output buffer with valid/ready handshake.
//   Reads are only issued while buffer entries plus reads in flight leave
//   room, so the buffer can never overflow.
//
// Ports
//   s_clk           sole clock, rising edge
//   s_rst           synchronous active-high reset
//   i_ramout_ready  RAM contents valid (level, sampled only while waiting)
//   i_start         single-cycle pulse, begins one frame when idle
//   o_rd_addr       RAM read address (data returns 2 cycles later)
//   i_ramout_data   RAM read data
//   o_data          stream data (buffer head)
//   o_valid         o_data valid
//   i_ready         downstream accept
//   o_busy          frame in progress
//   o_done          one-cycle pulse after the last beat transfers
module patch_embed_reader #(
  parameter int unsigned NUM_WORDS  = 4096,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              s_clk,
  input  logic              s_rst,
  input  logic              i_ramout_ready,
  input  logic              i_start,
  output logic [11:0]       o_rd_addr,
  input  logic [DATA_W-1:0] i_ramout_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_busy,
  output logic              o_done
);

  localparam int unsigned CNT_W  = 13;
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RDY,
    STREAM,
    DRAIN
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    issued_q, issued_d;
  logic [CNT_W-1:0]    beats_q, beats_d;
  logic [11:0]         last_addr_q, last_addr_d;
  logic                done_q, done_d;
  // bit 0: read issued last cycle, bit 1: read data on i_ramout_data now
  logic [1:0]          inflight_q, inflight_d;

  logic [DATA_W-1:0]   fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0]   fifo_count_q, fifo_count_d;

  logic                issue;
  logic                push;
  logic                pop;
  logic [FCNT_W:0]     credit_used;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Credit uses the registered occupancy, ignoring a pop happening this
  // cycle; this costs nothing in steady state and keeps the path short.
  assign credit_used = {1'b0, fifo_count_q}
                     + {{FCNT_W{1'b0}}, inflight_q[0]}
                     + {{FCNT_W{1'b0}}, inflight_q[1]};

  assign issue = (state_q == STREAM)
              && (credit_used < (FCNT_W+1)'(FIFO_DEPTH))
              && (issued_q < LAST_CNT);
  assign push  = inflight_q[1];
  assign pop   = (fifo_count_q != '0) && i_ready;

  // The address is presented in the issuing cycle itself so the RAM's
  // 2-cycle latency lines up with the 2-stage inflight shift register.
  assign o_rd_addr = issue ? issued_q[11:0] : last_addr_q;
  assign o_valid   = (fifo_count_q != '0);
  assign o_data    = fifo_mem_q[rd_ptr_q];
  assign o_busy    = (state_q != IDLE);
  assign o_done    = done_q;

  always_comb begin
    state_d     = state_q;
    issued_d    = issued_q;
    beats_d     = beats_q;
    last_addr_d = last_addr_q;
    done_d      = 1'b0;
    inflight_d  = {inflight_q[0], issue};
    wr_ptr_d    = push ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d    = pop  ? next_ptr(rd_ptr_q) : rd_ptr_q;

    unique case ({push, pop})
      2'b10:   fifo_count_d = fifo_count_q + FCNT_W'(1);
      2'b01:   fifo_count_d = fifo_count_q - FCNT_W'(1);
      default: fifo_count_d = fifo_count_q;
    endcase

    if (pop) begin
      beats_d = beats_q + CNT_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d  = WAIT_RDY;
          issued_d = '0;
          beats_d  = '0;
        end
      end
      WAIT_RDY: begin
        if (i_ramout_ready) begin
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (issue) begin
          issued_d    = issued_q + CNT_W'(1);
          last_addr_d = issued_q[11:0];
          if (issued_d == LAST_CNT) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && (beats_d == LAST_CNT)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      state_q      <= IDLE;
      issued_q     <= '0;
      beats_q      <= '0;
      last_addr_q  <= '0;
      done_q       <= 1'b0;
      inflight_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      issued_q     <= issued_d;
      beats_q      <= beats_d;
      last_addr_q  <= last_addr_d;
      done_q       <= done_d;
      inflight_q   <= inflight_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_count_q <= fifo_count_d;
      if (push) begin
        fifo_mem_q[wr_ptr_q] <= i_ramout_data;
      end
    end
  end

endmodule

// File: tb/tb_patch_embed_reader.sv
// Testbench for patch_embed_reader with NUM_WORDS=8, DATA_W=64, FIFO_DEPTH=4.
// A behavioural RAM with 2-cycle read latency feeds the DUT; each frame is
// scored against the expected word order, start-up latency, outstanding-read
// bound, stall stability and a single done pulse one cycle after the last beat.
module tb_patch_embed_reader;

  localparam int NW = 8;

  logic        s_clk = 1'b0;
  logic        s_rst;
  logic        i_ramout_ready;
  logic        i_start;
  logic [11:0] o_rd_addr;
  logic [63:0] i_ramout_data;
  logic [63:0] o_data;
  logic        o_valid;
  logic        i_ready;
  logic        o_busy;
  logic        o_done;

  patch_embed_reader #(
    .NUM_WORDS (NW),
    .DATA_W    (64),
    .FIFO_DEPTH(4)
  ) dut (
    .s_clk         (s_clk),
    .s_rst         (s_rst),
    .i_ramout_ready(i_ramout_ready),
    .i_start       (i_start),
    .o_rd_addr     (o_rd_addr),
    .i_ramout_data (i_ramout_data),
    .o_data        (o_data),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_busy        (o_busy),
    .o_done        (o_done)
  );

  always #5 s_clk = ~s_clk;

  // RAM model: address seen in cycle k -> data in cycle k+2
  logic [63:0] ram [NW];
  logic [11:0] a1 = '0;
  logic [11:0] a2 = '0;
  always @(posedge s_clk) begin
    a1 <= o_rd_addr;
    a2 <= a1;
  end
  always_comb i_ramout_data = (a2 < 12'(NW)) ? ram[a2[2:0]] : 64'h0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // mode: 0 ready always 1, 1 ready 0 for 'stall' cycles, 2 toggle 1,0,0,1,0,1, 3 random
  typedef struct {
    int rdy_delay;
    int mode;
    int stall;
    int extra_start;
    int drop_after;
    bit rand_ram;
    int exp_first_valid;
    int exp_last_beat;   // -1: not checked
  } vec_t;

  vec_t tbl [6];

  function automatic logic ready_at(input vec_t v, input int k);
    logic [5:0] tog;
    tog = 6'b101001;
    case (v.mode)
      0:       return 1'b1;
      1:       return (k >= v.stall);
      2:       return tog[k % 6];
      default: return ($urandom_range(0, 3) != 0);
    endcase
  endfunction

  // Cycle k is the interval after the k-th rising edge following the
  // edge that samples i_start. Inputs are driven #1 after each edge and
  // outputs sampled on the falling edge.
  task automatic run_frame(input vec_t v, input int idx);
    int beats = 0;
    int dones = 0;
    int first_valid = -1;
    int last_beat = -1;
    int done_cyc = -1;
    logic [11:0] addr_before;
    logic [63:0] held = '0;
    logic stalled = 1'b0;
    logic rdy;
    addr_before = o_rd_addr;
    for (int n = 0; n < NW; n++) ram[n] = v.rand_ram ? {$urandom, $urandom} : 64'(n);

    i_start        = 1'b1;
    i_ramout_ready = (v.rdy_delay == 0);
    i_ready        = 1'b0;
    @(posedge s_clk); #1;
    for (int k = 0; k < 150; k++) begin
      i_start        = (k == v.extra_start);
      i_ramout_ready = (k >= v.rdy_delay) && !((v.drop_after >= 0) && (k >= v.drop_after));
      rdy            = ready_at(v, k);
      i_ready        = rdy;
      @(negedge s_clk);
      if (o_done) begin
        dones++;
        done_cyc = k;
        chk($sformatf("f%0d done_one_after_last_beat", idx), 64'(k), 64'(last_beat + 1));
      end
      chk($sformatf("f%0d c%0d busy", idx, k), 64'(o_busy), 64'(dones == 0));
      if (k <= v.rdy_delay) begin
        chk($sformatf("f%0d c%0d wait_addr_held", idx, k), 64'(o_rd_addr), 64'(addr_before));
        chk($sformatf("f%0d c%0d wait_no_valid", idx, k), 64'(o_valid), 64'(0));
      end
      if (k == v.rdy_delay + 1)
        chk($sformatf("f%0d first_issue_addr", idx), 64'(o_rd_addr), 64'(0));
      if (k > v.rdy_delay && dones == 0)
        chk($sformatf("f%0d c%0d outstanding_le4", idx, k),
            64'((int'(o_rd_addr) + 1 - beats) <= 4), 64'(1));
      if (v.stall > 0 && k == v.stall - 1) begin
        chk($sformatf("f%0d stall_addr_stops_at_3", idx), 64'(o_rd_addr), 64'(3));
        chk($sformatf("f%0d stall_fifo_valid", idx), 64'(o_valid), 64'(1));
      end
      if (stalled) begin
        chk($sformatf("f%0d c%0d stall_valid_held", idx, k), 64'(o_valid), 64'(1));
        chk($sformatf("f%0d c%0d stall_data_held", idx, k), o_data, held);
      end
      if (o_valid && first_valid < 0) first_valid = k;
      if (o_valid && rdy) begin
        chk($sformatf("f%0d beat_within_frame", idx), 64'(beats < NW), 64'(1));
        if (beats < NW) chk($sformatf("f%0d beat%0d data", idx, beats), o_data, ram[beats]);
        beats++;
        last_beat = k;
      end
      stalled = o_valid && !rdy;
      held    = o_data;
      @(posedge s_clk); #1;
      if (done_cyc >= 0 && k >= done_cyc + 3) break;
    end
    i_start = 1'b0;
    chk($sformatf("f%0d beat_count", idx), 64'(beats), 64'(NW));
    chk($sformatf("f%0d done_count", idx), 64'(dones), 64'(1));
    chk($sformatf("f%0d first_valid_cycle", idx), 64'(first_valid), 64'(v.exp_first_valid));
    if (v.exp_last_beat >= 0)
      chk($sformatf("f%0d last_beat_cycle", idx), 64'(last_beat), 64'(v.exp_last_beat));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int beats;
    vec_t rv;

    //         dly mode stall xst  drop rand fv  last
    tbl[0] = '{0,  0,   0,    -1,  -1,  0,   4,  11};
    tbl[1] = '{10, 0,   0,    -1,  -1,  0,   14, 21};
    tbl[2] = '{0,  2,   0,    -1,  -1,  0,   4,  -1};
    tbl[3] = '{0,  1,   20,   -1,  -1,  0,   4,  27};
    tbl[4] = '{0,  0,   0,    3,   -1,  0,   4,  11};
    tbl[5] = '{2,  0,   0,    -1,  4,   1,   6,  13};

    for (int n = 0; n < NW; n++) ram[n] = 64'(n);
    s_rst = 1'b1; i_start = 1'b1; i_ramout_ready = 1'b1; i_ready = 1'b1;
    repeat (2) @(posedge s_clk);
    @(negedge s_clk);
    chk("reset o_valid", 64'(o_valid), 64'(0));
    chk("reset o_busy", 64'(o_busy), 64'(0));
    chk("reset o_done", 64'(o_done), 64'(0));
    chk("reset o_rd_addr", 64'(o_rd_addr), 64'(0));
    chk("reset o_data", o_data, 64'(0));
    @(posedge s_clk); #1;
    s_rst = 1'b0; i_start = 1'b0;
    @(posedge s_clk); #1;

    for (int t = 0; t < 6; t++) run_frame(tbl[t], t);

    // Reset after beat 3: frame abandoned silently, next start from address 0
    for (int n = 0; n < NW; n++) ram[n] = 64'(n);
    i_ramout_ready = 1'b1; i_ready = 1'b1; i_start = 1'b1;
    @(posedge s_clk); #1;
    i_start = 1'b0;
    beats = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge s_clk);
      if (o_valid && i_ready) begin
        chk($sformatf("abort beat%0d data", beats), o_data, ram[beats]);
        beats++;
      end
      if (beats == 4) break;
      @(posedge s_clk); #1;
    end
    chk("abort reached beat 3", 64'(beats), 64'(4));
    @(posedge s_clk); #1;
    s_rst = 1'b1;
    @(posedge s_clk); #1;
    s_rst = 1'b0;
    @(negedge s_clk);
    chk("abort o_valid", 64'(o_valid), 64'(0));
    chk("abort o_busy", 64'(o_busy), 64'(0));
    chk("abort o_done", 64'(o_done), 64'(0));
    for (int k = 0; k < 6; k++) begin
      @(posedge s_clk); #1;
      @(negedge s_clk);
      chk($sformatf("abort quiet c%0d done", k), 64'(o_done), 64'(0));
      chk($sformatf("abort quiet c%0d valid", k), 64'(o_valid), 64'(0));
    end
    @(posedge s_clk); #1;
    run_frame(tbl[0], 6);

    for (int r = 0; r < 12; r++) begin
      rv.rdy_delay       = int'($urandom_range(0, 6));
      rv.mode            = 3;
      rv.stall           = 0;
      rv.extra_start     = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 5)) : -1;
      rv.drop_after      = ($urandom_range(0, 1) != 0) ? rv.rdy_delay + 1 + int'($urandom_range(0, 4)) : -1;
      rv.rand_ram        = 1'b1;
      rv.exp_first_valid = rv.rdy_delay + 4;
      rv.exp_last_beat   = -1;
      run_frame(rv, 100 + r);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/patch_embed_reader.md
PATCH_EMBED_READER -- requirements
Module: patch_embed_reader

Interface
REQ-001 Parameter NUM_WORDS, default 4096, meaning: embedded-RAM words streamed per frame (1..4096).
REQ-002 Parameter DATA_W, default 64, meaning: RAM word width (2 bits per patch element).
REQ-003 Parameter FIFO_DEPTH, default 4, meaning: output buffer entries (fixed ≥4).
REQ-004 s_clk  in  1  sole clock; all logic on rising edge.
REQ-005 s_rst  in  1  synchronous, active-high reset.
REQ-006 i_ramout_ready  in  1  level: embedded RAM fully written, contents valid.
REQ-007 i_start  in  1  single-cycle pulse: begin streaming one frame.
REQ-008 o_rd_addr  out  12  RAM read address; RAM data appears on i_ramout_data exactly 2 cycles later.
REQ-009 i_ramout_data  in  DATA_W  RAM read data (2-cycle latency).
REQ-010 o_data  out  DATA_W  stream data, FIFO head.
REQ-011 o_valid  out  1  o_data valid.
REQ-012 i_ready  in  1  downstream accepts; a beat transfers when o_valid && i_ready.
REQ-013 o_busy  out  1  high from accepted start until done.
REQ-014 o_done  out  1  one-cycle pulse after the last beat transfers.

Function
REQ-015 FSM states IDLE, WAIT_RDY, STREAM, DRAIN; reset state IDLE.
REQ-016 IDLE: i_start -> WAIT_RDY, read counter, issue counter and beat counter cleared; i_start ignored in all other states.
REQ-017 WAIT_RDY: remain until i_ramout_ready=1, then -> STREAM; no reads issued in WAIT_RDY.
REQ-018 STREAM: one read issued per cycle when (fifo_count + inflight) < FIFO_DEPTH and issued < NUM_WORDS; o_rd_addr = issued count, incremented by 1 per issue.
REQ-019 Credit check uses registered counts before this cycle's pop (conservative); no FIFO overflow possible.
REQ-020 Inflight tracked by a 2-stage valid shift register aligned with RAM latency; stage-2 valid pushes i_ramout_data into FIFO that cycle.
REQ-021 STREAM -> DRAIN when issued reaches NUM_WORDS; DRAIN -> IDLE when beat counter reaches NUM_WORDS, with o_done pulsed in the cycle after the final transfer.
REQ-022 FIFO first-word-fall-through: o_valid = (fifo_count≠0); o_data = head entry; o_data held stable while o_valid && !i_ready.
REQ-023 Simultaneous push and pop: count unchanged, order preserved; push into empty FIFO makes o_valid high next cycle.
REQ-024 Throughput: with i_ready held high, one beat per cycle sustained after a 3-cycle start-up from STREAM entry (issue, 2 latency, push).
REQ-025 Beats delivered in address order 0..NUM_WORDS-1, no duplicates, no drops.
REQ-026 o_rd_addr holds last issued value when not issuing; 12-bit address never wraps within a frame.
REQ-027 i_ramout_ready dropping during STREAM/DRAIN ignored; frame completes.
REQ-028 o_busy = (state ≠ IDLE).

Reset
REQ-029 s_rst sampled on rising edge; overrides all other inputs including i_start.
REQ-030 Reset values: state IDLE, o_rd_addr 0, o_valid 0, o_busy 0, o_done 0, FIFO empty, inflight 0, all counters 0; o_data 0.
REQ-031 Reset mid-frame discards FIFO contents and inflight reads; no beat or o_done emitted for the aborted frame; next i_start begins again at address 0.

Verification
REQ-032 NUM_WORDS=8, RAM preloaded word n = n, i_ramout_ready=1, i_ready=1, start pulse -> beats 0..7 on 8 consecutive cycles, first o_valid 4 cycles after start, o_done 1 cycle after beat 7.
REQ-033 i_ramout_ready=0 at start, raised 10 cycles later -> no o_rd_addr change and o_valid=0 during wait; stream then identical to REQ-032.
REQ-034 i_ready toggled 1,0,0,1,0,1... -> fifo_count never exceeds 4, o_data stable while stalled, all 8 words delivered in order.
REQ-035 i_ready=0 for 20 cycles after start -> exactly 4 reads issued (addr 0..3), FIFO full, issue stops; release -> remaining words 4..7 follow in order.
REQ-036 s_rst asserted after beat 3 -> next cycle o_valid=0, o_busy=0, no o_done; new start delivers 0..7 from address 0.
REQ-037 Second i_start while busy -> ignored; exactly one o_done and 8 beats.
